// File: rtl/crystal_scan_pkg.sv
// Shared types and helpers for the crystal chain scanner and the ship logic that reuses
// its one-hot decoder.
package crystal_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_GAP    = 3'd2,
        ST_DRIVE  = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } onehot_dec_t;

    // One extra bit above the pin index so the all-ones NONE code never aliases a real pin.
    function automatic int ent_width(input int n_pins);
        return $clog2(n_pins) + 1;
    endfunction

    function automatic logic [7:0] none_code(input int ent_w);
        return 8'((32'd1 << ent_w) - 32'd1);
    endfunction

    function automatic onehot_dec_t onehot_to_idx(input logic [15:0] vec);
        onehot_dec_t res;
        res.valid = ($countones(vec) == 32'sd1);
        res.idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            res.idx = res.idx | (vec[i] ? 4'(i) : 4'd0);
        end
        return res;
    endfunction

endpackage

// File: rtl/crystal_onehot_decode.sv
// Combinational one-hot sense decoder: reports whether exactly one pin is set and which one.
module crystal_onehot_decode
    import crystal_scan_pkg::*;
#(
    parameter int N_PINS = 8,
    localparam int IDX_W = $clog2(N_PINS)
) (
    input  logic [N_PINS-1:0] sense,
    output logic              valid,
    output logic [IDX_W-1:0]  index
);

    onehot_dec_t dec_s;

    assign dec_s = onehot_to_idx(16'(sense));
    assign valid = dec_s.valid;
    assign index = IDX_W'(dec_s.idx);

endmodule

// File: rtl/crystal_chain_scanner.sv
// Probes the GPIO bank one pin per stage, decodes the synchronised sense bank and commits
// the discovered crystal map atomically once the scan finishes or aborts.
module crystal_chain_scanner
    import crystal_scan_pkg::*;
#(
    parameter int N_PINS        = 8,
    parameter int N_STAGES      = 8,
    parameter int SETTLE_CYCLES = 50000,
    parameter int START_PIN     = 0,
    localparam int ENT_W        = ent_width(N_PINS)
) (
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic                      get_crystal_array,
    input  logic                      chain_mode,
    input  logic [N_PINS-1:0]         GPIO_0i,
    output logic [N_PINS-1:0]         GPIO_0o,
    output logic [N_STAGES*ENT_W-1:0] map_o,
    output logic [N_STAGES-1:0]       stage_err_o,
    output logic                      loop_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int IDX_W = ENT_W - 1;
    localparam int STG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int TMR_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ENT_W-1:0]  NONE    = ENT_W'(none_code(ENT_W));
    localparam logic [N_PINS-1:0] PIN_ONE = {{(N_PINS-1){1'b0}}, 1'b1};

    scan_state_e               state_r, state_s;
    logic [N_PINS-1:0]         sense_meta_r, sense_sync_r;
    logic [STG_W-1:0]          stage_r;
    logic [TMR_W-1:0]          timer_r;
    logic                      mode_r;
    logic [N_STAGES*ENT_W-1:0] shadow_r, map_r;
    logic [N_STAGES-1:0]       serr_r, err_r;
    logic                      loop_r, loop_out_r;
    logic [N_PINS-1:0]         visited_r, drive_r;
    logic [IDX_W-1:0]          last_idx_r;
    logic                      busy_r, done_r;

    logic                      dec_valid_s;
    logic [IDX_W-1:0]          dec_idx_s;
    logic [IDX_W-1:0]          probe_idx_s;
    logic                      probe_en_s;
    logic [N_PINS-1:0]         probe_oh_s;
    logic                      sample_ok_s, loop_hit_s, abort_s, last_s;

    assign GPIO_0o     = drive_r;
    assign map_o       = map_r;
    assign stage_err_o = err_r;
    assign loop_o      = loop_out_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

    // Two-flop synchroniser for the asynchronous sense bank.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            sense_meta_r <= {N_PINS{1'b0}};
            sense_sync_r <= {N_PINS{1'b0}};
        end else begin
            sense_meta_r <= GPIO_0i;
            sense_sync_r <= sense_meta_r;
        end
    end

    crystal_onehot_decode #(.N_PINS(N_PINS)) u_decode (
        .sense (sense_sync_r),
        .valid (dec_valid_s),
        .index (dec_idx_s)
    );

    // Probe selection: chain mode follows the previous stage's answer, sweep walks the pins.
    always_comb begin
        probe_idx_s = IDX_W'(START_PIN);
        probe_en_s  = 1'b1;
        if (mode_r) begin
            if (stage_r == {STG_W{1'b0}}) begin
                probe_idx_s = IDX_W'(START_PIN);
            end else begin
                probe_idx_s = last_idx_r;
            end
        end else begin
            probe_idx_s = IDX_W'(stage_r);
            probe_en_s  = (int'(stage_r) < N_PINS);
        end
        probe_oh_s  = probe_en_s ? (PIN_ONE << probe_idx_s) : {N_PINS{1'b0}};
        sample_ok_s = dec_valid_s & probe_en_s;
        loop_hit_s  = mode_r & sample_ok_s & visited_r[dec_idx_s];
        abort_s     = mode_r & (~sample_ok_s | loop_hit_s);
        last_s      = (int'(stage_r) == N_STAGES - 1);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (get_crystal_array) state_s = ST_ARMED;
                else                   state_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (!get_crystal_array) state_s = ST_GAP;
                else                    state_s = ST_ARMED;
            end
            ST_GAP:   state_s = ST_DRIVE;
            ST_DRIVE: begin
                if (timer_r == TMR_W'(SETTLE_CYCLES - 1)) state_s = ST_SAMPLE;
                else                                      state_s = ST_DRIVE;
            end
            ST_SAMPLE: begin
                if (last_s || abort_s) state_s = ST_DONE;
                else                   state_s = ST_GAP;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register, probe drive, shadow capture and atomic commit of the results.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            stage_r    <= {STG_W{1'b0}};
            timer_r    <= {TMR_W{1'b0}};
            mode_r     <= 1'b0;
            shadow_r   <= {N_STAGES{NONE}};
            serr_r     <= {N_STAGES{1'b0}};
            loop_r     <= 1'b0;
            visited_r  <= {N_PINS{1'b0}};
            last_idx_r <= {IDX_W{1'b0}};
            drive_r    <= {N_PINS{1'b0}};
            map_r      <= {N_STAGES{NONE}};
            err_r      <= {N_STAGES{1'b0}};
            loop_out_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            drive_r <= (state_s == ST_DRIVE || state_s == ST_SAMPLE) ? probe_oh_s
                                                                     : {N_PINS{1'b0}};
            done_r  <= 1'b0;
            case (state_r)
                ST_ARMED: begin
                    if (!get_crystal_array) begin
                        mode_r    <= chain_mode;
                        stage_r   <= {STG_W{1'b0}};
                        shadow_r  <= {N_STAGES{NONE}};
                        serr_r    <= {N_STAGES{1'b0}};
                        loop_r    <= 1'b0;
                        visited_r <= {N_PINS{1'b0}};
                        busy_r    <= 1'b1;
                    end
                end
                ST_GAP:   timer_r <= {TMR_W{1'b0}};
                ST_DRIVE: timer_r <= timer_r + TMR_W'(1);
                ST_SAMPLE: begin
                    if (sample_ok_s) begin
                        shadow_r[int'(stage_r)*ENT_W +: ENT_W] <= {1'b0, dec_idx_s};
                        visited_r[dec_idx_s] <= 1'b1;
                        last_idx_r           <= dec_idx_s;
                        if (loop_hit_s) loop_r <= 1'b1;
                    end else begin
                        serr_r[stage_r] <= 1'b1;
                    end
                    // Stages an abort never reaches are flagged as errors too.
                    if (abort_s) begin
                        for (int j = 0; j < N_STAGES; j++) begin
                            if (j > int'(stage_r)) serr_r[j] <= 1'b1;
                        end
                    end
                    if (!abort_s && !last_s) stage_r <= stage_r + STG_W'(1);
                end
                ST_DONE: begin
                    map_r      <= shadow_r;
                    err_r      <= serr_r;
                    loop_out_r <= loop_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crystal_chain_scanner.sv
// Directed bench for crystal_chain_scanner: wired chains, bad reads, loops, sweep mode,
// mid-scan reset and request handling while busy.
module tb_crystal_chain_scanner;

    logic        system_clk = 1'b0;
    logic        rst;
    logic        get_crystal_array;
    logic        chain_mode;
    logic [7:0]  GPIO_0i;
    logic [7:0]  GPIO_0o;
    logic [31:0] map_o;
    logic [7:0]  stage_err_o;
    logic        loop_o;
    logic        busy_o;
    logic        done_o;

    logic [7:0]  conn [8];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          done_cnt   = 0;
    int          drive_cyc  = 0;
    int          drive_bad  = 0;
    int          lat, d0, c0;

    always #5 system_clk = ~system_clk;

    crystal_chain_scanner #(
        .N_PINS(8), .N_STAGES(8), .SETTLE_CYCLES(8), .START_PIN(0)
    ) dut (
        .system_clk        (system_clk),
        .rst               (rst),
        .get_crystal_array (get_crystal_array),
        .chain_mode        (chain_mode),
        .GPIO_0i           (GPIO_0i),
        .GPIO_0o           (GPIO_0o),
        .map_o             (map_o),
        .stage_err_o       (stage_err_o),
        .loop_o            (loop_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    // Crystal wiring model: each driven probe pin reflects its patched sense pattern.
    always_comb begin
        GPIO_0i = 8'h00;
        for (int p = 0; p < 8; p++) begin
            if (GPIO_0o[p]) GPIO_0i = GPIO_0i | conn[p];
        end
    end

    always @(negedge system_clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (GPIO_0o != 8'h00) drive_cyc <= drive_cyc + 1;
        if ($countones(GPIO_0o) > 1) drive_bad <= drive_bad + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_conn();
        for (int p = 0; p < 8; p++) conn[p] = 8'h00;
    endtask

    task automatic link(input int p, input int q);
        conn[p] = 8'b0000_0001 << q;
    endtask

    task automatic wire_chain1();
        clear_conn();
        link(0, 3); link(3, 5); link(5, 1); link(1, 6);
        link(6, 2); link(2, 7); link(7, 4); link(4, 0);
    endtask

    // Request, release, then count negedges until done_o (latency 82 for a full 8-stage scan).
    task automatic run_scan(input logic mode, input int hold, input bit toggle, output int lat_o);
        chain_mode        = mode;
        get_crystal_array = 1'b1;
        repeat (hold) @(negedge system_clk);
        get_crystal_array = 1'b0;
        lat_o = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge system_clk);
            if (toggle) begin
                get_crystal_array = (i >= 10 && i < 50 && ((i / 10) % 2 == 1));
                if (i == 60) check_eq("t6_map_hold", map_o, 32'hFFFF_FFFF);
            end
            if (done_o) begin
                lat_o = i;
                break;
            end
        end
        get_crystal_array = 1'b0;
        repeat (3) @(negedge system_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; get_crystal_array = 1'b0; chain_mode = 1'b0;
        clear_conn();
        repeat (3) @(negedge system_clk);
        check_eq("rst_gpio",  {24'h0, GPIO_0o},     32'h0);
        check_eq("rst_map",   map_o,                32'hFFFF_FFFF);
        check_eq("rst_err",   {24'h0, stage_err_o}, 32'h0);
        check_eq("rst_flags", {29'h0, loop_o, busy_o, done_o}, 32'h0);
        rst = 1'b0;
        @(negedge system_clk);

        // 1: full chain 0->3->5->1->6->2->7->4->0
        wire_chain1();
        d0 = done_cnt; c0 = drive_cyc;
        run_scan(1'b1, 2, 1'b0, lat);
        check_eq("t1_latency", lat, 32'd82);
        check_eq("t1_map",     map_o, 32'h0472_6153);
        check_eq("t1_err",     {24'h0, stage_err_o}, 32'h0);
        check_eq("t1_loop",    {31'h0, loop_o}, 32'h0);
        check_eq("t1_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t1_drive_cyc", drive_cyc - c0, 32'd72);
        check_eq("t1_busy_after", {31'h0, busy_o}, 32'h0);

        // 2: stage 2 probes pin 5 and reads a non-one-hot pattern
        conn[5] = 8'b0000_0101;
        c0 = drive_cyc;
        run_scan(1'b1, 2, 1'b0, lat);
        check_eq("t2_latency", lat, 32'd32);
        check_eq("t2_map",     map_o, 32'hFFFF_FF53);
        check_eq("t2_err",     {24'h0, stage_err_o}, 32'h0000_00FC);
        check_eq("t2_drive_cyc", drive_cyc - c0, 32'd27);

        // 3: chain 0->2->0, pin 2 is found again by stage 2
        clear_conn();
        link(0, 2); link(2, 0);
        run_scan(1'b1, 2, 1'b0, lat);
        check_eq("t3_latency", lat, 32'd32);
        check_eq("t3_loop",    {31'h0, loop_o}, 32'h1);
        check_eq("t3_map",     map_o, 32'hFFFF_F202);
        check_eq("t3_err",     {24'h0, stage_err_o}, 32'h0000_00F8);

        // 4: sweep, identity wiring, pin 4 open
        clear_conn();
        for (int p = 0; p < 8; p++) if (p != 4) link(p, p);
        c0 = drive_cyc;
        run_scan(1'b0, 2, 1'b0, lat);
        check_eq("t4_latency", lat, 32'd82);
        check_eq("t4_map",     map_o, 32'h765F_3210);
        check_eq("t4_err",     {24'h0, stage_err_o}, 32'h0000_0010);
        check_eq("t4_loop",    {31'h0, loop_o}, 32'h0);
        check_eq("t4_drive_cyc", drive_cyc - c0, 32'd72);

        // 5: reset during stage 3 drive (probing pin 1)
        wire_chain1();
        chain_mode = 1'b1; get_crystal_array = 1'b1;
        repeat (2) @(negedge system_clk);
        get_crystal_array = 1'b0;
        repeat (34) @(negedge system_clk);
        check_eq("t5_pre_gpio", {24'h0, GPIO_0o}, 32'h0000_0002);
        check_eq("t5_pre_busy", {31'h0, busy_o}, 32'h1);
        rst = 1'b1;
        d0 = done_cnt;
        @(negedge system_clk);
        check_eq("t5_gpio", {24'h0, GPIO_0o}, 32'h0);
        check_eq("t5_busy", {31'h0, busy_o}, 32'h0);
        check_eq("t5_map",  map_o, 32'hFFFF_FFFF);
        check_eq("t5_done", {31'h0, done_o}, 32'h0);
        rst = 1'b0;
        repeat (100) @(negedge system_clk);
        check_eq("t5_no_done", done_cnt, d0);
        check_eq("t5_idle_busy", {31'h0, busy_o}, 32'h0);

        // 6: request held high, then toggled while busy
        chain_mode = 1'b1; get_crystal_array = 1'b1;
        repeat (20) @(negedge system_clk);
        check_eq("t6_held_busy", {31'h0, busy_o}, 32'h0);
        check_eq("t6_held_gpio", {24'h0, GPIO_0o}, 32'h0);
        d0 = done_cnt;
        run_scan(1'b1, 1, 1'b1, lat);
        check_eq("t6_latency", lat, 32'd82);
        check_eq("t6_map",     map_o, 32'h0472_6153);
        check_eq("t6_done_cnt", done_cnt - d0, 32'd1);
        repeat (20) @(negedge system_clk);
        check_eq("t6_no_restart", {31'h0, busy_o}, 32'h0);

        check_eq("drive_onehot", drive_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
